acq_event_sequencer: RTL

Parametrised acquisition sequencer for the DiscFerret capture path: it arms on START, optionally waits for an arming strobe, counts qualifying start events, runs the acquisition, and counts qualifying stop events before returning to idle. It generalises the fixed 2-source index/sync-word acquisition control to NUM_EVT maskable event channels and wider counters. It adds a hard RAM-full stop, an optional start-wait timeout, and a termination-reason report. It sits in the CLK_MASTER domain between the track-mark and sync-word detectors and the sample-RAM writer.

---
 rtl/acq_event_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/acq_event_sequencer.sv
// Acquisition sequencer: arm, count start events, acquire, count stop events.
// Define ACQSEQ_TIMEOUT_EN to build the TICK-based start-wait timeout.
module acq_event_sequencer #(
    parameter int NUM_EVT = 4,
    parameter int CNT_W   = 8,
    parameter int TMO_W   = 16
) (
    input  logic               CLK_MASTER,
    input  logic               RESET_N,
    input  logic               START,
    input  logic               ABORT,
    input  logic [NUM_EVT-1:0] EVT_IN,
    input  logic [NUM_EVT-1:0] START_MASK,
    input  logic [NUM_EVT-1:0] STOP_MASK,
    input  logic [CNT_W-1:0]   START_NUM,
    input  logic [CNT_W-1:0]   STOP_NUM,
    input  logic               START_ARM_REQ,
    input  logic               STOP_ARM_REQ,
    input  logic               ARM_EVT,
    input  logic               SR_R_FULL,
    input  logic               TICK,
    input  logic [TMO_W-1:0]   TIMEOUT,
    output logic               WAITING,
    output logic               ACQUIRING,
    output logic               DONE,
    output logic [1:0]         STOP_REASON
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ARMS = 3'd1,
        S_WAIT = 3'd2,
        S_ARME = 3'd3,
        S_ACQ  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_EVT-1:0] evt_dly_q, evt_dly_d;
    logic [CNT_W-1:0]   scnt_q, scnt_d;
    logic [CNT_W-1:0]   ecnt_q, ecnt_d;
    logic               waiting_q, waiting_d;
    logic               acquiring_q, acquiring_d;
    logic               done_q, done_d;
    logic [1:0]         reason_q, reason_d;

    logic [NUM_EVT-1:0] evt_edge;
    logic               smatch;
    logic               ematch;
    logic               abort_hit;
    logic               tmo_hit;

`ifdef ACQSEQ_TIMEOUT_EN
    logic [TMO_W-1:0]   tcnt_q, tcnt_d;

    assign tmo_hit = (TIMEOUT != '0) && (tcnt_q == TIMEOUT);
`else
    logic               unused_tmo;

    assign unused_tmo = TICK ^ (^TIMEOUT);
    assign tmo_hit    = 1'b0;
`endif

    // An all-zero mask means "do not wait on any channel".
    assign evt_edge  = EVT_IN & ~evt_dly_q;
    assign smatch    = (START_MASK == '0) || ((evt_edge & START_MASK) != '0);
    assign ematch    = (STOP_MASK == '0) || ((evt_edge & STOP_MASK) != '0);
    assign abort_hit = ABORT &&
                       (state_q inside {S_ARMS, S_WAIT, S_ARME, S_ACQ});

    always_comb begin
        state_d   = state_q;
        evt_dly_d = EVT_IN;
        scnt_d    = scnt_q;
        ecnt_d    = ecnt_q;
        done_d    = 1'b0;
        reason_d  = reason_q;
`ifdef ACQSEQ_TIMEOUT_EN
        tcnt_d    = tcnt_q;
`endif
        if (abort_hit) begin
            state_d  = S_IDLE;
            done_d   = 1'b1;
            reason_d = 2'd3;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (START && !ABORT) begin
                        scnt_d   = START_NUM;
                        ecnt_d   = STOP_NUM;
                        reason_d = 2'd0;
`ifdef ACQSEQ_TIMEOUT_EN
                        tcnt_d   = '0;
`endif
                        if (START_ARM_REQ) state_d = S_ARMS;
                        else               state_d = S_WAIT;
                    end
                end
                S_ARMS: begin
                    if (ARM_EVT) state_d = S_WAIT;
                end
                S_WAIT: begin
`ifdef ACQSEQ_TIMEOUT_EN
                    // Hold at the limit so a match-masked timeout fires next cycle.
                    if (TICK && !tmo_hit && (tcnt_q != '1))
                        tcnt_d = tcnt_q + 1'b1;
`endif
                    if (smatch) begin
                        if (scnt_q != '0)      scnt_d  = scnt_q - 1'b1;
                        else if (STOP_ARM_REQ) state_d = S_ARME;
                        else                   state_d = S_ACQ;
                    end else if (tmo_hit) begin
                        state_d  = S_IDLE;
                        done_d   = 1'b1;
                        reason_d = 2'd2;
                    end
                end
                S_ARME: begin
                    if (ARM_EVT) state_d = S_ACQ;
                end
                S_ACQ: begin
                    if (SR_R_FULL) begin
                        state_d  = S_IDLE;
                        done_d   = 1'b1;
                        reason_d = 2'd1;
                    end else if (ematch) begin
                        if (ecnt_q != '0) begin
                            ecnt_d = ecnt_q - 1'b1;
                        end else begin
                            state_d  = S_IDLE;
                            done_d   = 1'b1;
                            reason_d = 2'd0;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        waiting_d   = (state_d == S_ARMS) || (state_d == S_WAIT);
        acquiring_d = (state_d == S_ARME) || (state_d == S_ACQ);
    end

    always_ff @(posedge CLK_MASTER or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            evt_dly_q   <= '0;
            scnt_q      <= '0;
            ecnt_q      <= '0;
            waiting_q   <= 1'b0;
            acquiring_q <= 1'b0;
            done_q      <= 1'b0;
            reason_q    <= 2'd0;
        end else begin
            state_q     <= state_d;
            evt_dly_q   <= evt_dly_d;
            scnt_q      <= scnt_d;
            ecnt_q      <= ecnt_d;
            waiting_q   <= waiting_d;
            acquiring_q <= acquiring_d;
            done_q      <= done_d;
            reason_q    <= reason_d;
        end
    end

`ifdef ACQSEQ_TIMEOUT_EN
    always_ff @(posedge CLK_MASTER or negedge RESET_N) begin
        if (!RESET_N) tcnt_q <= '0;
        else          tcnt_q <= tcnt_d;
    end
`endif

    assign WAITING     = waiting_q;
    assign ACQUIRING   = acquiring_q;
    assign DONE        = done_q;
    assign STOP_REASON = reason_q;

endmodule
